gnn_layer_engine: RTL and testbench

//  Parametrised, sequential GNN layer: optional one-hop neighbour aggregation, then dense transform
//  out[n][j] = sum_i h[n][i]*w[i][j]. All nodes and output columns compute in parallel.

---
 rtl/gnn_layer_engine_if.sv | 29 ++
 rtl/gnn_layer_engine.sv | 139 +++++++++++++
 tb/tb_gnn_layer_engine.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/gnn_layer_engine_if.sv
// Bundle-in / result-out handshake for gnn_layer_engine.
// master = producer/consumer side, slave = engine side.
interface gnn_layer_engine_if #(
   parameter int N_NODES = 4,
   parameter int F_IN    = 4,
   parameter int F_OUT   = 2,
   parameter int DW      = 5,
   parameter int AW      = 20
);
   logic                          in_valid;
   logic                          in_ready;
   logic [N_NODES*F_IN*DW-1:0]    x_flat;
   logic [F_IN*F_OUT*DW-1:0]      w_flat;
   logic [N_NODES*N_NODES-1:0]    adj;
   logic                          out_valid;
   logic                          out_ready;
   logic [N_NODES*F_OUT*AW-1:0]   out_data;
   logic                          ovf;

   modport master (
      output in_valid, x_flat, w_flat, adj, out_ready,
      input  in_ready, out_valid, out_data, ovf
   );

   modport slave (
      input  in_valid, x_flat, w_flat, adj, out_ready,
      output in_ready, out_valid, out_data, ovf
   );
endinterface

// File: rtl/gnn_layer_engine.sv
// GNN layer: optional one-hop neighbour sum, then dense transform, one input index per clock.
// state | meaning
// IDLE  | waiting for a bundle; in_ready high
// AGG   | one cycle of neighbour aggregation into h
// MAC   | accumulate h[n][idx]*w[idx][j] for all n,j; idx counts up
// DONE  | result held on out_data/ovf until out_ready
module gnn_layer_engine #(
   parameter int N_NODES = 4,
   parameter int F_IN    = 4,
   parameter int F_OUT   = 2,
   parameter int DW      = 5,
   parameter int AW      = 20,
   parameter bit AGG_EN  = 1'b0,
   parameter bit SAT     = 1'b1
) (
   input logic             clk,
   input logic             rst_n,
   gnn_layer_engine_if.slave bus
);
   localparam int HW = DW + $clog2(N_NODES);
   localparam int FW = HW + DW + $clog2(F_IN);
   localparam int IW = (F_IN > 1) ? $clog2(F_IN) : 1;
   // AW wider than the accumulator simply zero-extends; overflow is then impossible.
   localparam int EW = (FW > AW) ? FW : AW;
   localparam logic [EW-1:0] LIM = EW'({AW{1'b1}});

   generate
      if (F_IN < 1 || N_NODES < 1) begin : g_bad_cfg
         $error("gnn_layer_engine: F_IN and N_NODES must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, AGG, MAC, DONE} state_t;

   state_t                       state_q, state_d;
   logic [N_NODES*F_IN*HW-1:0]   h_q, h_d;
   logic [F_IN*F_OUT*DW-1:0]     w_q, w_d;
   logic [N_NODES*N_NODES-1:0]   adj_q, adj_d;
   logic [N_NODES*F_OUT*FW-1:0]  acc_q, acc_d;
   logic [IW-1:0]                idx_q, idx_d;
   logic [N_NODES*F_OUT*AW-1:0]  out_data_q, out_data_d;
   logic                         ovf_q, ovf_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         h_q        <= '0;
         w_q        <= '0;
         adj_q      <= '0;
         acc_q      <= '0;
         idx_q      <= '0;
         out_data_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         h_q        <= h_d;
         w_q        <= w_d;
         adj_q      <= adj_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         out_data_q <= out_data_d;
         ovf_q      <= ovf_d;
      end
   end

   always_comb begin
      logic [HW-1:0]    hsum;
      logic [HW+DW-1:0] prod;
      logic [FW-1:0]    accn;
      logic [EW-1:0]    acc_ext;
      state_d    = state_q;
      h_d        = h_q;
      w_d        = w_q;
      adj_d      = adj_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      out_data_d = out_data_q;
      ovf_d      = ovf_q;
      hsum       = '0;
      prod       = '0;
      accn       = '0;
      acc_ext    = '0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               // raw features land in h; AGG rewrites them in place when enabled
               for (int n = 0; n < N_NODES; n++)
                  for (int i = 0; i < F_IN; i++)
                     h_d[(n*F_IN+i)*HW +: HW] = HW'(bus.x_flat[(n*F_IN+i)*DW +: DW]);
               w_d     = bus.w_flat;
               adj_d   = bus.adj;
               acc_d   = '0;
               idx_d   = '0;
               ovf_d   = 1'b0;
               state_d = AGG_EN ? AGG : MAC;
            end
         end
         AGG: begin
            for (int n = 0; n < N_NODES; n++)
               for (int i = 0; i < F_IN; i++) begin
                  hsum = h_q[(n*F_IN+i)*HW +: HW];
                  for (int m = 0; m < N_NODES; m++)
                     if (m != n && adj_q[n*N_NODES+m])
                        hsum = hsum + h_q[(m*F_IN+i)*HW +: HW];
                  h_d[(n*F_IN+i)*HW +: HW] = hsum;
               end
            state_d = MAC;
         end
         MAC: begin
            for (int n = 0; n < N_NODES; n++)
               for (int j = 0; j < F_OUT; j++) begin
                  prod = h_q[(n*F_IN+int'(idx_q))*HW +: HW] * w_q[(int'(idx_q)*F_OUT+j)*DW +: DW];
                  accn = acc_q[(n*F_OUT+j)*FW +: FW] + FW'(prod);
                  acc_d[(n*F_OUT+j)*FW +: FW] = accn;
                  acc_ext = EW'(accn);
                  if (idx_q == IW'(F_IN-1)) begin
                     if (acc_ext > LIM) begin
                        ovf_d = 1'b1;
                        out_data_d[(n*F_OUT+j)*AW +: AW] = SAT ? {AW{1'b1}} : acc_ext[AW-1:0];
                     end else begin
                        out_data_d[(n*F_OUT+j)*AW +: AW] = acc_ext[AW-1:0];
                     end
                  end
               end
            if (idx_q == IW'(F_IN-1)) state_d = DONE;
            else                      idx_d   = idx_q + 1'b1;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE) & rst_n;
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_data  = out_data_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_gnn_layer_engine.sv
// Directed bench for gnn_layer_engine: plain, aggregating, and AW=8 saturating/wrapping instances.
module tb_gnn_layer_engine;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   gnn_layer_engine_if #(.AW(20)) bus_a ();
   gnn_layer_engine_if #(.AW(20)) bus_b ();
   gnn_layer_engine_if #(.AW(8))  bus_c ();
   gnn_layer_engine_if #(.AW(8))  bus_d ();

   gnn_layer_engine #(.AW(20), .AGG_EN(1'b0), .SAT(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   gnn_layer_engine #(.AW(20), .AGG_EN(1'b1), .SAT(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
   gnn_layer_engine #(.AW(8),  .AGG_EN(1'b0), .SAT(1'b1)) u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));
   gnn_layer_engine #(.AW(8),  .AGG_EN(1'b0), .SAT(1'b0)) u_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [19:0] row4(input int a, input int b, input int c, input int d);
      return {d[4:0], c[4:0], b[4:0], a[4:0]};
   endfunction

   function automatic logic [39:0] wmat(input int a0, input int a1, input int a2, input int a3,
                                        input int b0, input int b1, input int b2, input int b3);
      return {b3[4:0], a3[4:0], b2[4:0], a2[4:0], b1[4:0], a1[4:0], b0[4:0], a0[4:0]};
   endfunction

   function automatic logic [19:0] oa(input int n, input int j);
      return bus_a.out_data[(n*2+j)*20 +: 20];
   endfunction
   function automatic logic [19:0] ob(input int n, input int j);
      return bus_b.out_data[(n*2+j)*20 +: 20];
   endfunction
   function automatic logic [7:0] oc(input int n, input int j);
      return bus_c.out_data[(n*2+j)*8 +: 8];
   endfunction
   function automatic logic [7:0] od(input int n, input int j);
      return bus_d.out_data[(n*2+j)*8 +: 8];
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [39:0] w_t1;
      logic [79:0] x_t1;
      int lat;
      int n_acc;
      logic acc_now;
      logic [19:0] r00 [$];
      logic [19:0] r01 [$];
      logic        rov [$];

      w_t1 = wmat(3, 2, 13, 26, 23, 1, 28, 14);
      x_t1 = {row4(0,0,0,0), row4(0,0,0,0), row4(0,0,0,0), row4(4,2,4,1)};

      rst_n = 1'b0;
      bus_a.in_valid = 0; bus_a.x_flat = '0; bus_a.w_flat = '0; bus_a.adj = '0; bus_a.out_ready = 0;
      bus_b.in_valid = 0; bus_b.x_flat = '0; bus_b.w_flat = '0; bus_b.adj = '0; bus_b.out_ready = 0;
      bus_c.in_valid = 0; bus_c.x_flat = '0; bus_c.w_flat = '0; bus_c.adj = '0; bus_c.out_ready = 0;
      bus_d.in_valid = 0; bus_d.x_flat = '0; bus_d.w_flat = '0; bus_d.adj = '0; bus_d.out_ready = 0;
      tick();
      tick();
      chk("rst_in_ready", bus_a.in_ready, 0);
      chk("rst_out_valid", bus_a.out_valid, 0);
      chk("rst_out_data", bus_a.out_data, 0);
      chk("rst_ovf", bus_a.ovf, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_in_ready", bus_a.in_ready, 1);

      // T1: plain transform, latency F_IN
      bus_a.x_flat = x_t1; bus_a.w_flat = w_t1; bus_a.in_valid = 1;
      tick();
      bus_a.in_valid = 0;
      bus_a.x_flat = '1;
      chk("t1_busy_in_ready", bus_a.in_ready, 0);
      lat = 0;
      while (!bus_a.out_valid && lat < 20) begin tick(); lat++; end
      chk("t1_latency", lat, 4);
      chk("t1_out00", oa(0,0), 94);
      chk("t1_out01", oa(0,1), 220);
      chk("t1_out10", oa(1,0), 0);
      chk("t1_ovf", bus_a.ovf, 0);

      // T4: hold in DONE under backpressure while inputs churn
      for (int k = 0; k < 10; k++) begin
         bus_a.in_valid = k[0];
         bus_a.x_flat = {16'($urandom), $urandom, $urandom};
         tick();
         chk("t4_hold_data", oa(0,1), 220);
         chk("t4_hold_valid", bus_a.out_valid, 1);
         chk("t4_hold_in_ready", bus_a.in_ready, 0);
      end
      bus_a.in_valid = 0;
      bus_a.out_ready = 1;
      tick();
      bus_a.out_ready = 0;
      chk("t4_valid_drop", bus_a.out_valid, 0);
      chk("t4_in_ready_back", bus_a.in_ready, 1);
      chk("t4_data_kept", oa(0,0), 94);

      // T2: aggregation with full adjacency, then a sparse one with a diagonal bit
      bus_b.x_flat = {row4(6,4,4,1), row4(8,6,4,1), row4(6,4,4,1), row4(4,2,4,1)};
      bus_b.w_flat = w_t1; bus_b.adj = 16'hFFFF; bus_b.in_valid = 1;
      tick();
      bus_b.in_valid = 0;
      lat = 0;
      while (!bus_b.out_valid && lat < 20) begin tick(); lat++; end
      chk("t2_latency", lat, 5);
      chk("t2_out00", ob(0,0), 416);
      chk("t2_out11", ob(1,1), 1072);
      chk("t2_out30", ob(3,0), 416);
      bus_b.out_ready = 1;
      tick();
      bus_b.out_ready = 0;
      bus_b.adj = 16'h0003;
      bus_b.in_valid = 1;
      tick();
      bus_b.in_valid = 0;
      lat = 0;
      while (!bus_b.out_valid && lat < 20) begin tick(); lat++; end
      chk("t2b_latency", lat, 5);
      chk("t2b_out00", ob(0,0), 198);
      chk("t2b_out10", ob(1,0), 104);

      // T3: AW=8 saturate vs wrap
      bus_c.x_flat = '1; bus_c.w_flat = '1; bus_c.in_valid = 1;
      bus_d.x_flat = '1; bus_d.w_flat = '1; bus_d.in_valid = 1;
      tick();
      bus_c.in_valid = 0; bus_d.in_valid = 0;
      lat = 0;
      while (!bus_c.out_valid && lat < 20) begin tick(); lat++; end
      chk("t3_latency", lat, 4);
      chk("t3_sat_out00", oc(0,0), 255);
      chk("t3_sat_out31", oc(3,1), 255);
      chk("t3_sat_ovf", bus_c.ovf, 1);
      chk("t3_wrap_valid", bus_d.out_valid, 1);
      chk("t3_wrap_out00", od(0,0), 4);
      chk("t3_wrap_out21", od(2,1), 4);
      chk("t3_wrap_ovf", bus_d.ovf, 1);

      // T5: reset in the middle of MAC
      bus_a.x_flat = x_t1; bus_a.w_flat = w_t1; bus_a.in_valid = 1;
      tick();
      bus_a.in_valid = 0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("t5_rst_data", bus_a.out_data, 0);
      chk("t5_rst_valid", bus_a.out_valid, 0);
      chk("t5_rst_in_ready", bus_a.in_ready, 0);
      tick();
      chk("t5_low_in_ready", bus_a.in_ready, 0);
      rst_n = 1'b1;
      tick();
      bus_a.in_valid = 1;
      tick();
      bus_a.in_valid = 0;
      lat = 0;
      while (!bus_a.out_valid && lat < 20) begin tick(); lat++; end
      chk("t5_latency", lat, 4);
      chk("t5_out00", oa(0,0), 94);
      chk("t5_out01", oa(0,1), 220);
      bus_a.out_ready = 1;
      tick();

      // T6: back-to-back bundles with out_ready tied high
      n_acc = 0;
      bus_a.x_flat = x_t1; bus_a.w_flat = w_t1; bus_a.in_valid = 1;
      for (int c = 0; c < 40; c++) begin
         acc_now = bus_a.in_ready & bus_a.in_valid;
         tick();
         if (acc_now) begin
            n_acc++;
            if (n_acc == 1) begin bus_a.x_flat = '1; bus_a.w_flat = '1; end
            else bus_a.in_valid = 0;
         end
         if (bus_a.out_valid) begin
            r00.push_back(oa(0,0));
            r01.push_back(oa(0,1));
            rov.push_back(bus_a.ovf);
         end
      end
      chk("t6_accepts", n_acc, 2);
      chk("t6_results", r00.size(), 2);
      if (r00.size() == 2) begin
         chk("t6_r0_out00", r00[0], 94);
         chk("t6_r0_out01", r01[0], 220);
         chk("t6_r0_ovf", rov[0], 0);
         chk("t6_r1_out00", r00[1], 3844);
         chk("t6_r1_out01", r01[1], 3844);
         chk("t6_r1_ovf", rov[1], 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
